// File: rtl/flash_status_poller.sv
// flash_status_poller: repeatedly issues RDSR over the shared SPI controller
// until the flash WIP bit reads clear, then reports ready to the requester.
// Optional macro POLLER_TIMEOUT_EN enables the poll limit / timeout pulse.
module flash_status_poller #(
  parameter logic [7:0]  RDSR_OPCODE = 8'h05,
  parameter int unsigned WIP_BIT     = 0,
  parameter int unsigned GAP_CYCLES  = 16,
  parameter int unsigned MAX_POLLS   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_poll_start,
  output logic        out_poll_busy,
  output logic        out_poll_done,
  output logic        out_poll_timeout,
  output logic [7:0]  out_status,
  output logic        out_spi_start,
  output logic [15:0] out_spi_num_bytes,
  input  logic        in_spi_busy,
  input  logic        in_spi_done,
  output logic        out_spi_tx_valid,
  output logic [7:0]  out_spi_tx_data,
  input  logic        in_spi_tx_ready,
  input  logic        in_spi_rx_valid,
  input  logic [7:0]  in_spi_rx_data,
  output logic        out_spi_rx_ready
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  // Parameter sanity: a zero gap would underflow the gap counter load.
  if (GAP_CYCLES < 1) begin : g_gap_check
    $error("GAP_CYCLES must be at least 1");
  end
  if (MAX_POLLS < 1) begin : g_poll_check
    $error("MAX_POLLS must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CMD,
    S_DUMMY,
    S_WAIT,
    S_EVAL,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]       rx_idx_q, rx_idx_d;
  logic [7:0]       status_q, status_d;
  logic             rx_ready;
  logic             rx_fire;
  logic             poll_limit;

`ifdef POLLER_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(MAX_POLLS + 1);

  logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;

  // Poll counter: cleared on acceptance, counts each completed transaction.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (state_q == S_IDLE && in_poll_start) begin
      poll_cnt_d = '0;
    end else if (state_q == S_WAIT && in_spi_done) begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end
  end

  // Poll counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt_q <= '0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign poll_limit = (poll_cnt_q == POLL_W'(MAX_POLLS));
`else
  // Without the timeout feature the poller waits for WIP forever.
  assign poll_limit = 1'b0;
`endif

  assign rx_ready          = (state_q == S_CMD) || (state_q == S_DUMMY) || (state_q == S_WAIT);
  assign rx_fire           = in_spi_rx_valid && rx_ready;
  assign out_spi_rx_ready  = rx_ready;
  assign out_poll_busy     = (state_q != S_IDLE);
  assign out_spi_num_bytes = out_poll_busy ? 16'd2 : 16'd0;
  assign out_status        = status_q;

  // Next-state, rx capture and SPI/handshake outputs.
  always_comb begin
    state_d          = state_q;
    gap_cnt_d        = gap_cnt_q;
    rx_idx_d         = rx_idx_q;
    status_d         = status_q;
    out_spi_start    = 1'b0;
    out_spi_tx_valid = 1'b0;
    out_spi_tx_data  = 8'h00;
    out_poll_done    = 1'b0;
    out_poll_timeout = 1'b0;

    // Byte 0 echoes the opcode slot and is dropped; byte 1 is the status.
    if (rx_fire) begin
      if (rx_idx_q == 2'd1) begin
        status_d = in_spi_rx_data;
      end
      if (rx_idx_q != 2'd3) begin
        rx_idx_d = rx_idx_q + 2'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (in_poll_start) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (!in_spi_busy) begin
          out_spi_start = 1'b1;
          rx_idx_d      = 2'd0;
          state_d       = S_CMD;
        end
      end
      S_CMD: begin
        out_spi_tx_valid = 1'b1;
        out_spi_tx_data  = RDSR_OPCODE;
        if (in_spi_tx_ready) begin
          state_d = S_DUMMY;
        end
      end
      S_DUMMY: begin
        out_spi_tx_valid = 1'b1;
        out_spi_tx_data  = 8'h00;
        if (in_spi_tx_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (in_spi_done) begin
          state_d = S_EVAL;
          // A truncated transfer gives no trustworthy status: assume busy.
          if (rx_idx_d < 2'd2) begin
            status_d = 8'hFF;
          end
        end
      end
      S_EVAL: begin
        if (!status_q[WIP_BIT]) begin
          out_poll_done = 1'b1;
          state_d       = S_IDLE;
        end else if (poll_limit) begin
          out_poll_timeout = 1'b1;
          state_d          = S_IDLE;
        end else begin
          gap_cnt_d = GAP_W'(GAP_CYCLES - 1);
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_ARM;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, gap counter, rx index and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      gap_cnt_q <= '0;
      rx_idx_q  <= 2'd0;
      status_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      rx_idx_q  <= rx_idx_d;
      status_q  <= status_d;
    end
  end

endmodule

// File: tb/tb_flash_status_poller.sv
// Directed testbench for flash_status_poller with a small SPI controller model.
// Build with POLLER_TIMEOUT_EN defined to also exercise the timeout path.
module tb_flash_status_poller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_poll_start = 1'b0;
  logic        out_poll_busy;
  logic        out_poll_done;
  logic        out_poll_timeout;
  logic [7:0]  out_status;
  logic        out_spi_start;
  logic [15:0] out_spi_num_bytes;
  logic        in_spi_busy = 1'b0;
  logic        in_spi_done = 1'b0;
  logic        out_spi_tx_valid;
  logic [7:0]  out_spi_tx_data;
  logic        in_spi_tx_ready = 1'b0;
  logic        in_spi_rx_valid = 1'b0;
  logic [7:0]  in_spi_rx_data = 8'h00;
  logic        out_spi_rx_ready;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Per-transaction responder configuration
  logic [7:0] cfg_status [0:7];
  int         cfg_rx     [0:7];
  int         cfg_stall  [0:7];
  int         busy_force = 0;
  bit         hold_done = 1'b0;
  bit         restart_armed = 1'b0;
  bit         restart_drop = 1'b0;

  // Responder state
  bit         in_xfer = 1'b0;
  int         tx_count = 0;
  int         cur = 0;
  int         stall_cnt = 0;
  bit         done_now = 1'b0;
  logic [7:0] rxq [$];

  // Monitor state
  int         n_start = 0;
  int         n_done = 0;
  int         n_timeout = 0;
  int         req_cycle = 0;
  int         poll_done_cyc = 0;
  int         last_spi_done = -10;
  int         start_cyc [$];
  int         spi_done_cyc [$];
  logic [7:0] tx_log [$];
  logic [7:0] eval_status [$];
  int         early_tx = 0;
  int         hold_err = 0;
  int         stall_seen = 0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  flash_status_poller #(
    .RDSR_OPCODE(8'h05),
    .WIP_BIT    (0),
    .GAP_CYCLES (16),
    .MAX_POLLS  (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .in_poll_start    (in_poll_start),
    .out_poll_busy    (out_poll_busy),
    .out_poll_done    (out_poll_done),
    .out_poll_timeout (out_poll_timeout),
    .out_status       (out_status),
    .out_spi_start    (out_spi_start),
    .out_spi_num_bytes(out_spi_num_bytes),
    .in_spi_busy      (in_spi_busy),
    .in_spi_done      (in_spi_done),
    .out_spi_tx_valid (out_spi_tx_valid),
    .out_spi_tx_data  (out_spi_tx_data),
    .in_spi_tx_ready  (in_spi_tx_ready),
    .in_spi_rx_valid  (in_spi_rx_valid),
    .in_spi_rx_data   (in_spi_rx_data),
    .out_spi_rx_ready (out_spi_rx_ready)
  );

  always #5 clk = ~clk;

  // SPI controller model and monitor: drive at negedge, observe 1 time unit later
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      done_now        = in_xfer && (tx_count == 2) && (rxq.size() == 0) && !hold_done;
      in_spi_done     = done_now;
      in_spi_busy     = (busy_force > 0) || in_xfer;
      if (busy_force > 0) busy_force--;
      in_spi_tx_ready = in_xfer && (stall_cnt == 0) && (tx_count < 2);
      in_spi_rx_valid = (rxq.size() > 0);
      in_spi_rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
      if (restart_armed && (cyc == last_spi_done + 1)) begin
        in_poll_start = 1'b1;
        restart_armed = 1'b0;
        restart_drop  = 1'b1;
      end else if (restart_drop) begin
        in_poll_start = 1'b0;
        restart_drop  = 1'b0;
      end
      #1;
      if (out_spi_tx_valid && !in_xfer) early_tx++;
      if (prev_hold && (!out_spi_tx_valid || out_spi_tx_data !== prev_data)) hold_err++;
      prev_hold = out_spi_tx_valid && !in_spi_tx_ready;
      prev_data = out_spi_tx_data;
      if (out_spi_start) begin
        n_start++;
        start_cyc.push_back(cyc);
        cur       = (n_start < 8) ? n_start - 1 : 7;
        in_xfer   = 1'b1;
        tx_count  = 0;
        stall_cnt = cfg_stall[cur];
      end
      if (out_spi_tx_valid && !in_spi_tx_ready && in_xfer && stall_cnt > 0) begin
        stall_cnt--;
        stall_seen++;
      end
      if (out_spi_tx_valid && in_spi_tx_ready) begin
        tx_log.push_back(out_spi_tx_data);
        if (tx_count < cfg_rx[cur]) rxq.push_back((tx_count == 0) ? 8'hAA : cfg_status[cur]);
        tx_count++;
      end
      if (in_spi_rx_valid && out_spi_rx_ready) void'(rxq.pop_front());
      if (done_now) begin
        in_xfer = 1'b0;
        spi_done_cyc.push_back(cyc);
        last_spi_done = cyc;
      end
      if (cyc == last_spi_done + 1) eval_status.push_back(out_status);
      if (out_poll_done) begin
        n_done++;
        poll_done_cyc = cyc;
      end
      if (out_poll_timeout) n_timeout++;
    end
  end

  task automatic clear_mon(input logic [7:0] status);
    for (int i = 0; i < 8; i++) begin
      cfg_status[i] = status;
      cfg_rx[i]     = 2;
      cfg_stall[i]  = 0;
    end
    n_start = 0; n_done = 0; n_timeout = 0;
    early_tx = 0; hold_err = 0; stall_seen = 0;
    start_cyc.delete(); spi_done_cyc.delete(); tx_log.delete(); eval_status.delete();
  endtask

  task automatic request_start();
    @(negedge clk);
    #2;
    in_poll_start = 1'b1;
    req_cycle = cyc;
    @(negedge clk);
    #2;
    in_poll_start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #2;
      if (n_done + n_timeout > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (out_poll_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b exp=0", out_poll_busy); end
    checks++; if (out_spi_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_start got=%b exp=0", out_spi_start); end
    checks++; if (out_spi_tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tx_valid got=%b exp=0", out_spi_tx_valid); end
    checks++; if (out_spi_rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_rx_ready got=%b exp=0", out_spi_rx_ready); end
    checks++; if (out_status !== 8'h00) begin errors++; $display("[TB] FAIL reset_status got=%h exp=00", out_status); end
    checks++; if (out_spi_num_bytes !== 16'd0) begin errors++; $display("[TB] FAIL reset_num_bytes got=%0d exp=0", out_spi_num_bytes); end
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (out_poll_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got=%b exp=0", out_poll_busy); end
  endtask

  task automatic test_first_poll_ready();
    bit to;
    clear_mon(8'h00);
    request_start();
    wait_end(100, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL first_wait got=timeout exp=done"); end
    checks++; if (n_start !== 1) begin errors++; $display("[TB] FAIL first_starts got=%0d exp=1", n_start); end
    checks++; if (start_cyc.size() > 0 && start_cyc[0] - req_cycle !== 1) begin errors++; $display("[TB] FAIL first_start_lat got=%0d exp=1", start_cyc[0] - req_cycle); end
    checks++; if (tx_log.size() != 2 || tx_log[0] !== 8'h05 || tx_log[1] !== 8'h00) begin errors++; $display("[TB] FAIL first_tx_bytes got_n=%0d exp=05,00", tx_log.size()); end
    checks++; if (out_status !== 8'h00) begin errors++; $display("[TB] FAIL first_status got=%h exp=00", out_status); end
    checks++; if (spi_done_cyc.size() > 0 && poll_done_cyc - spi_done_cyc[0] !== 1) begin errors++; $display("[TB] FAIL first_done_lat got=%0d exp=1", poll_done_cyc - spi_done_cyc[0]); end
    checks++; if (n_timeout !== 0) begin errors++; $display("[TB] FAIL first_timeout got=%0d exp=0", n_timeout); end
    @(negedge clk); #2;
    checks++; if (out_poll_busy !== 1'b0 || out_spi_num_bytes !== 16'd0) begin errors++; $display("[TB] FAIL first_idle got=%b/%0d exp=0/0", out_poll_busy, out_spi_num_bytes); end
  endtask

  task automatic test_repoll();
    bit to;
    clear_mon(8'h03);
    cfg_status[3] = 8'h02;
    request_start();
    wait_end(400, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL repoll_wait got=timeout exp=done"); end
    checks++; if (n_start !== 4) begin errors++; $display("[TB] FAIL repoll_starts got=%0d exp=4", n_start); end
    checks++; if (n_done !== 1) begin errors++; $display("[TB] FAIL repoll_dones got=%0d exp=1", n_done); end
    checks++; if (out_status !== 8'h02) begin errors++; $display("[TB] FAIL repoll_status got=%h exp=02", out_status); end
    for (int k = 1; k < start_cyc.size(); k++) begin
      checks++;
      if (start_cyc[k] - spi_done_cyc[k-1] < 17) begin errors++; $display("[TB] FAIL repoll_gap%0d got=%0d exp>=17", k, start_cyc[k] - spi_done_cyc[k-1]); end
    end
    checks++; if (tx_log.size() != 8) begin errors++; $display("[TB] FAIL repoll_tx_count got=%0d exp=8", tx_log.size()); end
  endtask

  task automatic test_spi_busy();
    bit to;
    clear_mon(8'h00);
    @(negedge clk);
    #2;
    in_poll_start = 1'b1;
    req_cycle = cyc;
    busy_force = 10;
    @(negedge clk);
    #2;
    in_poll_start = 1'b0;
    wait_end(100, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL busy_wait got=timeout exp=done"); end
    checks++; if (start_cyc.size() > 0 && start_cyc[0] - req_cycle !== 11) begin errors++; $display("[TB] FAIL busy_start_lat got=%0d exp=11", start_cyc[0] - req_cycle); end
    checks++; if (early_tx !== 0) begin errors++; $display("[TB] FAIL busy_early_tx got=%0d exp=0", early_tx); end
  endtask

  task automatic test_short_rx_stall();
    bit to;
    clear_mon(8'h00);
    cfg_rx[0]    = 1;
    cfg_stall[0] = 5;
    request_start();
    wait_end(200, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL short_wait got=timeout exp=done"); end
    checks++; if (eval_status.size() < 1 || eval_status[0] !== 8'hFF) begin errors++; $display("[TB] FAIL short_status_ff got=%h exp=ff", (eval_status.size() > 0) ? eval_status[0] : 8'hxx); end
    checks++; if (n_start !== 2) begin errors++; $display("[TB] FAIL short_starts got=%0d exp=2", n_start); end
    checks++; if (out_status !== 8'h00) begin errors++; $display("[TB] FAIL short_final_status got=%h exp=00", out_status); end
    checks++; if (stall_seen !== 5) begin errors++; $display("[TB] FAIL stall_cycles got=%0d exp=5", stall_seen); end
    checks++; if (hold_err !== 0) begin errors++; $display("[TB] FAIL stall_hold got=%0d exp=0", hold_err); end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_mon(8'h00);
    restart_armed = 1'b1;
    request_start();
    wait_end(100, to);
    repeat (25) @(negedge clk);
    #2;
    checks++; if (to) begin errors++; $display("[TB] FAIL b2b_wait got=timeout exp=done"); end
    checks++; if (n_start !== 1) begin errors++; $display("[TB] FAIL b2b_starts got=%0d exp=1", n_start); end
    checks++; if (out_poll_busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy got=%b exp=0", out_poll_busy); end
  endtask

  task automatic test_reset_in_wait();
    bit to;
    bit reached;
    clear_mon(8'h01);
    hold_done = 1'b1;
    request_start();
    reached = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #2;
      if (tx_count == 2 && in_xfer) begin reached = 1'b1; break; end
    end
    checks++; if (!reached) begin errors++; $display("[TB] FAIL rstw_reach got=0 exp=1"); end
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (out_poll_busy !== 1'b0) begin errors++; $display("[TB] FAIL rstw_busy got=%b exp=0", out_poll_busy); end
    checks++; if (out_spi_rx_ready !== 1'b0) begin errors++; $display("[TB] FAIL rstw_rx_ready got=%b exp=0", out_spi_rx_ready); end
    checks++; if (out_spi_num_bytes !== 16'd0) begin errors++; $display("[TB] FAIL rstw_num_bytes got=%0d exp=0", out_spi_num_bytes); end
    checks++; if (out_status !== 8'h00) begin errors++; $display("[TB] FAIL rstw_status got=%h exp=00", out_status); end
    in_xfer = 1'b0; tx_count = 0; rxq.delete(); hold_done = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    checks++; if (n_done !== 0 || n_timeout !== 0) begin errors++; $display("[TB] FAIL rstw_no_pulse got=%0d/%0d exp=0/0", n_done, n_timeout); end
    clear_mon(8'h04);
    request_start();
    wait_end(100, to);
    checks++; if (to || n_done !== 1) begin errors++; $display("[TB] FAIL rstw_repoll_done got=%0d exp=1", n_done); end
    checks++; if (out_status !== 8'h04) begin errors++; $display("[TB] FAIL rstw_repoll_status got=%h exp=04", out_status); end
    checks++; if (n_start !== 1) begin errors++; $display("[TB] FAIL rstw_repoll_starts got=%0d exp=1", n_start); end
  endtask

`ifdef POLLER_TIMEOUT_EN
  task automatic test_timeout();
    bit to;
    clear_mon(8'h01);
    request_start();
    wait_end(400, to);
    repeat (3) @(negedge clk);
    #2;
    checks++; if (to) begin errors++; $display("[TB] FAIL timeout_wait got=hang exp=timeout"); end
    checks++; if (n_start !== 4) begin errors++; $display("[TB] FAIL timeout_starts got=%0d exp=4", n_start); end
    checks++; if (n_timeout !== 1) begin errors++; $display("[TB] FAIL timeout_pulses got=%0d exp=1", n_timeout); end
    checks++; if (n_done !== 0) begin errors++; $display("[TB] FAIL timeout_dones got=%0d exp=0", n_done); end
    checks++; if (out_poll_busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout_busy got=%b exp=0", out_poll_busy); end
  endtask
`endif

  initial begin
    clear_mon(8'h00);
    test_reset();
    test_first_poll_ready();
    test_repoll();
    test_spi_busy();
    test_short_rx_stall();
    test_back_to_back();
    test_reset_in_wait();
`ifdef POLLER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_watchdog got=expired exp=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
